fft_stage_sequencer: RTL and testbench

//  Address/control sequencer for the radix-2 in-place DIF FFT engine. After sample padding it walks
//  log2(N) stages of N/2 butterflies and drives, per butterfly, two read addresses, a twiddle ROM

---
 rtl/fft_stage_sequencer_if.sv | 32 +++
 rtl/fft_stage_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_stage_sequencer_if.sv
// Handshake and memory-control bundle between the FFT stage sequencer and
// the FFT top FSM, the two sample BRAMs, the twiddle ROM and the butterfly.
interface fft_stage_sequencer_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] stage;
  logic                  rd_en;
  logic                  rd_bank;
  logic [ADDR_WIDTH-1:0] rd_addr_a;
  logic [ADDR_WIDTH-1:0] rd_addr_b;
  logic [ADDR_WIDTH-1:0] tf_addr;
  logic                  wr_en;
  logic                  wr_bank;
  logic [ADDR_WIDTH-1:0] wr_addr_a;
  logic [ADDR_WIDTH-1:0] wr_addr_b;
  logic                  result_bank;

  modport master (
    input  start,
    output busy, done, stage, rd_en, rd_bank, rd_addr_a, rd_addr_b, tf_addr,
           wr_en, wr_bank, wr_addr_a, wr_addr_b, result_bank
  );

  modport slave (
    output start,
    input  busy, done, stage, rd_en, rd_bank, rd_addr_a, rd_addr_b, tf_addr,
           wr_en, wr_bank, wr_addr_a, wr_addr_b, result_bank
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Address/control sequencer for a radix-2 in-place DIF FFT: walks log2(N) stages of
// N/2 butterflies, ping-pongs between two banks and replays read addresses as writes.
module fft_stage_sequencer #(
  parameter int N          = 64,
  parameter int ADDR_WIDTH = $clog2(N),
  parameter int PIPE_LAT   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  fft_stage_sequencer_if.master bus
);

  localparam int AW = ADDR_WIDTH;
  localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [AW-1:0] K_LAST   = AW'(N / 2 - 1);
  localparam logic [AW-1:0] S_LAST   = AW'(AW - 1);
  localparam logic [CW-1:0] C_LAST   = CW'(PIPE_LAT - 1);
  localparam logic          RES_BANK = ((AW % 2) == 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  function automatic logic [AW-1:0] low_mask(input logic [AW-1:0] p);
    return ~({AW{1'b1}} << p);
  endfunction

  // Butterfly upper address: k with a zero spliced in at bit p.
  function automatic logic [AW-1:0] upper_addr(input logic [AW-1:0] k, input logic [AW-1:0] p);
    logic [AW-1:0] m;
    m = low_mask(p);
    return ((k & ~m) << 1) | (k & m);
  endfunction

  function automatic logic [AW-1:0] twiddle_idx(input logic [AW-1:0] k, input logic [AW-1:0] p,
                                                input logic [AW-1:0] s);
    return (k & low_mask(p)) << s;
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] p_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW-1:0] stage_q, stage_d;
  logic          rd_en_q, rd_en_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [AW-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [AW-1:0] tf_addr_q, tf_addr_d;
  logic          result_bank_q, result_bank_d;

  logic          dly_vld_q  [PIPE_LAT];
  logic          dly_vld_d  [PIPE_LAT];
  logic          dly_bank_q [PIPE_LAT];
  logic          dly_bank_d [PIPE_LAT];
  logic [AW-1:0] dly_a_q    [PIPE_LAT];
  logic [AW-1:0] dly_a_d    [PIPE_LAT];
  logic [AW-1:0] dly_b_q    [PIPE_LAT];
  logic [AW-1:0] dly_b_d    [PIPE_LAT];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          k_d     = '0;
          s_d     = '0;
        end
      end
      RUN: begin
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == C_LAST) begin
          k_d = '0;
          if (s_q == S_LAST) begin
            state_d = FIN;
          end else begin
            state_d = RUN;
            s_d     = s_q + AW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
        s_d     = '0;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    p_d           = S_LAST - s_d;
    rd_en_d       = (state_d == RUN);
    busy_d        = (state_d != IDLE);
    done_d        = (state_q == FIN);
    stage_d       = s_d;
    rd_bank_d     = rd_en_d & s_d[0];
    rd_addr_a_d   = rd_en_d ? upper_addr(k_d, p_d) : '0;
    rd_addr_b_d   = rd_en_d ? (upper_addr(k_d, p_d) | (AW'(1) << p_d)) : '0;
    tf_addr_d     = rd_en_d ? twiddle_idx(k_d, p_d, s_d) : '0;
    result_bank_d = (state_q == FIN) ? RES_BANK : result_bank_q;
  end

  always_comb begin
    dly_vld_d[0]  = rd_en_q;
    dly_bank_d[0] = rd_en_q & ~rd_bank_q;
    dly_a_d[0]    = rd_addr_a_q;
    dly_b_d[0]    = rd_addr_b_q;
    for (int i = 1; i < PIPE_LAT; i++) begin
      dly_vld_d[i]  = dly_vld_q[i-1];
      dly_bank_d[i] = dly_bank_q[i-1];
      dly_a_d[i]    = dly_a_q[i-1];
      dly_b_d[i]    = dly_b_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      k_q           <= '0;
      s_q           <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      stage_q       <= '0;
      rd_en_q       <= 1'b0;
      rd_bank_q     <= 1'b0;
      rd_addr_a_q   <= '0;
      rd_addr_b_q   <= '0;
      tf_addr_q     <= '0;
      result_bank_q <= 1'b0;
      dly_vld_q     <= '{default: 1'b0};
      dly_bank_q    <= '{default: 1'b0};
      dly_a_q       <= '{default: '0};
      dly_b_q       <= '{default: '0};
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      s_q           <= s_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      stage_q       <= stage_d;
      rd_en_q       <= rd_en_d;
      rd_bank_q     <= rd_bank_d;
      rd_addr_a_q   <= rd_addr_a_d;
      rd_addr_b_q   <= rd_addr_b_d;
      tf_addr_q     <= tf_addr_d;
      result_bank_q <= result_bank_d;
      dly_vld_q     <= dly_vld_d;
      dly_bank_q    <= dly_bank_d;
      dly_a_q       <= dly_a_d;
      dly_b_q       <= dly_b_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.stage       = stage_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.rd_bank     = rd_bank_q;
  assign bus.rd_addr_a   = rd_addr_a_q;
  assign bus.rd_addr_b   = rd_addr_b_q;
  assign bus.tf_addr     = tf_addr_q;
  assign bus.wr_en       = dly_vld_q[PIPE_LAT-1];
  assign bus.wr_bank     = dly_bank_q[PIPE_LAT-1];
  assign bus.wr_addr_a   = dly_a_q[PIPE_LAT-1];
  assign bus.wr_addr_b   = dly_b_q[PIPE_LAT-1];
  assign bus.result_bank = result_bank_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: a schedule model indexed by cycles since the first
// read predicts every output; random start noise and aborting resets exercise control.
module tb_fft_stage_sequencer;
  localparam int NN  = 64;
  localparam int LL  = 6;
  localparam int PL  = 3;
  localparam int PER = NN / 2 + PL;
  localparam int TOT = LL * PER;

  logic clk;
  logic rst;
  fft_stage_sequencer_if #(.ADDR_WIDTH(LL)) bus ();

  fft_stage_sequencer #(.N(NN), .ADDR_WIDTH(LL), .PIPE_LAT(PL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // k-th address (ascending) whose bit p is clear: the upper leg of butterfly k.
  function automatic int pair_lo(input int s, input int k);
    int p;
    int cnt;
    p = LL - 1 - s;
    cnt = 0;
    for (int a = 0; a < NN; a++) begin
      if (((a >> p) & 1) == 0) begin
        if (cnt == k) return a;
        cnt++;
      end
    end
    return -1;
  endfunction

  // Model: m_t counts cycles since the first read of the current transform.
  int m_t = 0;
  bit m_run = 0;
  bit m_done = 0;
  always @(posedge clk) begin
    m_done = 0;
    if (rst) begin
      m_run = 0;
      m_t   = 0;
    end else if (m_run) begin
      m_t++;
      if (m_t == TOT + 1) begin
        m_run  = 0;
        m_done = 1;
      end
    end else if (bus.start) begin
      m_run = 1;
      m_t   = 0;
    end
  end

  int cyc = 0;
  int first_rd = 0;
  int wcnt[LL][NN];
  int rdc[LL];

  always @(negedge clk) begin
    bit exp_rd;
    bit exp_wr;
    int s, k, a, p, tw, bad;
    cyc++;
    if (chk_en) begin
      exp_rd = m_run && (m_t < TOT) && ((m_t % PER) < NN / 2);
      exp_wr = m_run && (m_t >= PL) && (((m_t - PL) % PER) < NN / 2) && (m_t - PL < TOT);
      if (m_run && m_t == 0) begin
        for (int i = 0; i < LL; i++) begin
          rdc[i] = 0;
          for (int j = 0; j < NN; j++) wcnt[i][j] = 0;
        end
        first_rd = cyc;
      end
      chk("busy", int'(bus.busy), int'(m_run));
      chk("done", int'(bus.done), int'(m_done));
      chk("rd_en", int'(bus.rd_en), int'(exp_rd));
      chk("wr_en", int'(bus.wr_en), int'(exp_wr));
      if (exp_rd) begin
        s = m_t / PER;
        k = m_t % PER;
        p = LL - 1 - s;
        a = pair_lo(s, k);
        rdc[s] += int'(bus.rd_en);
        chk("stage", int'(bus.stage), s);
        chk("rd_bank", int'(bus.rd_bank), s & 1);
        chk("rd_addr_a", int'(bus.rd_addr_a), a);
        chk("rd_addr_b", int'(bus.rd_addr_b), a + (1 << p));
        chk("tf_addr", int'(bus.tf_addr), ((a & ((1 << p) - 1)) << s) & (NN - 1));
        if (m_t == 5) begin
          chk("lit_s0k5_a", int'(bus.rd_addr_a), 5);
          chk("lit_s0k5_b", int'(bus.rd_addr_b), 37);
          chk("lit_s0k5_tf", int'(bus.tf_addr), 5);
        end
        if (m_t == 2 * PER + 13) begin
          chk("lit_s2k13_a", int'(bus.rd_addr_a), 21);
          chk("lit_s2k13_b", int'(bus.rd_addr_b), 29);
          chk("lit_s2k13_tf", int'(bus.tf_addr), 20);
        end
        if (m_t == 5 * PER + 5) begin
          chk("lit_s5k5_a", int'(bus.rd_addr_a), 10);
          chk("lit_s5k5_b", int'(bus.rd_addr_b), 11);
          chk("lit_s5k5_bank", int'(bus.rd_bank), 1);
        end
      end
      if (exp_wr) begin
        tw = m_t - PL;
        s  = tw / PER;
        k  = tw % PER;
        p  = LL - 1 - s;
        a  = pair_lo(s, k);
        chk("wr_bank", int'(bus.wr_bank), 1 - (s & 1));
        chk("wr_addr_a", int'(bus.wr_addr_a), a);
        chk("wr_addr_b", int'(bus.wr_addr_b), a + (1 << p));
        if (bus.wr_en) begin
          wcnt[s][int'(bus.wr_addr_a)]++;
          wcnt[s][int'(bus.wr_addr_b)]++;
        end
        if (m_t == 8) begin
          chk("lit_wr5_a", int'(bus.wr_addr_a), 5);
          chk("lit_wr5_b", int'(bus.wr_addr_b), 37);
          chk("lit_wr5_bank", int'(bus.wr_bank), 1);
        end
      end
      if (m_done) begin
        bad = 0;
        for (int i = 0; i < LL; i++) begin
          if (rdc[i] != NN / 2) bad++;
          for (int j = 0; j < NN; j++) if (wcnt[i][j] != 1) bad++;
        end
        chk("rd_count_wr_once", bad, 0);
        chk("done_latency", cyc - first_rd, 211);
        chk("result_bank", int'(bus.result_bank), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_done(input bit noise);
    bit seen;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      bus.start = noise && m_run && (m_t < TOT - 10) && ($urandom_range(0, 3) == 0);
      if (m_done) begin
        seen = 1;
        break;
      end
    end
    bus.start = 1'b0;
    chk("done_seen", int'(seen), 1);
  endtask

  task automatic run_to_t(input int target);
    bit seen;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (m_run && m_t == target) begin
        seen = 1;
        break;
      end
    end
    chk("reached_t", int'(seen), 1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic abort_now();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_wr_en", int'(bus.wr_en), 0);
    chk("abort_rd_en", int'(bus.rd_en), 0);
  endtask

  initial begin
    int tgt;
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    chk_en = 1;
    tick();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_rd_en", int'(bus.rd_en), 0);
    chk("rst_wr_en", int'(bus.wr_en), 0);
    chk("rst_stage", int'(bus.stage), 0);
    chk("rst_addrs", int'(bus.rd_addr_a) + int'(bus.rd_addr_b) + int'(bus.tf_addr)
        + int'(bus.wr_addr_a) + int'(bus.wr_addr_b), 0);
    chk("rst_banks", int'(bus.rd_bank) + int'(bus.wr_bank) + int'(bus.result_bank), 0);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (3) tick();
    chk("idle_after_rst", int'(bus.busy), 0);

    pulse_start();
    run_to_done(1'b1);
    tick();
    pulse_start();
    chk("restart_busy", int'(bus.busy), 1);
    chk("restart_rd_en", int'(bus.rd_en), 1);
    chk("restart_addr_k0", int'(bus.rd_addr_a), 0);

    tgt = 3 * PER + NN / 2 + $urandom_range(0, PL - 1);
    run_to_t(tgt);
    chk("drain_stage3", int'(bus.stage), 3);
    abort_now();
    repeat (2) tick();
    pulse_start();
    chk("fresh_k0_a", int'(bus.rd_addr_a), 0);
    chk("fresh_k0_b", int'(bus.rd_addr_b), 32);
    run_to_done(1'b0);

    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(1, 5)) tick();
      pulse_start();
      if ($urandom_range(0, 1) == 1) begin
        run_to_t($urandom_range(1, TOT - 1));
        abort_now();
      end else begin
        run_to_done(1'b1);
      end
    end
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
